// File: rtl/decompressor_ring_pkg.sv
// ---------------------------------------------------------------------------
// decompressor_ring_pkg
// Shared definitions for the bitstream decompressor: state encodings, buffer
// geometry, the bit-width clamp constant and small helper functions.
// Optional feature macro used by the design: DECOMP_SIGN_EXT_EN
// ---------------------------------------------------------------------------
package decompressor_ring_pkg;

  localparam int MAXBITWIDTH    = 16;
  localparam int INPUT_BITWIDTH = 16;
  localparam int BUF_SIZE       = 2 * INPUT_BITWIDTH;
  localparam int FILL_W         = 6;   // holds 0..32
  localparam int BITS_LEFT_W    = 37;  // 32-bit count times up to 16 bits

  // Widths of 0 or above the maximum fall back to the full width.
  localparam logic [4:0] BW_CLAMP = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Map an unsupported configured width onto the full width.
  function automatic logic [4:0] clamp_bw(input logic [4:0] bw);
    logic [4:0] res;
    if ((bw == 5'd0) || (bw > BW_CLAMP)) begin
      res = BW_CLAMP;
    end else begin
      res = bw;
    end
    return res;
  endfunction

  // Low-order mask of bw ones (bw in 1..16); 17-bit intermediate keeps bw=16 exact.
  function automatic logic [15:0] value_mask(input logic [4:0] bw);
    logic [16:0] one_hot;
    one_hot = 17'd1 << bw;
    return 16'(one_hot - 17'd1);
  endfunction

endpackage

// File: rtl/decompressor_ring_extract.sv
// ---------------------------------------------------------------------------
// decompressor_ring_extract
// Combinational field extractor: takes the low 16 buffer bits and the active
// value width, masks off the value and widens it to MAXBITWIDTH.
// With DECOMP_SIGN_EXT_EN defined the value is sign-extended from bit bw-1,
// otherwise it is zero-extended.
// Ports:
//   bits_i  [15:0]  low bits of the bit buffer
//   bw_i    [4:0]   value width, 1..16
//   value_o [15:0]  extended value
// ---------------------------------------------------------------------------
module decompressor_ring_extract
  import decompressor_ring_pkg::*;
(
  input  logic [15:0] bits_i,
  input  logic [4:0]  bw_i,
  output logic [15:0] value_o
);

  logic [15:0] mask_s;
  logic [15:0] raw_s;
  logic        sign_s;

  // Mask the field and apply the configured extension.
  always_comb begin
    mask_s  = value_mask(bw_i);
    raw_s   = bits_i & mask_s;
    sign_s  = bits_i[4'(bw_i - 5'd1)];
`ifdef DECOMP_SIGN_EXT_EN
    if (sign_s) begin
      value_o = raw_s | ~mask_s;
    end else begin
      value_o = raw_s;
    end
`else
    if (sign_s) begin
      value_o = raw_s;   // unsigned codes: sign bit carries no extension
    end else begin
      value_o = raw_s;
    end
`endif
  end

endmodule

// File: rtl/decompressor_ring.sv
// ---------------------------------------------------------------------------
// decompressor_ring
// Unpacks a dense LSB-first stream of 16-bit words holding back-to-back
// bw-bit values and emits one widened value per output handshake.
// Optional feature macro: DECOMP_SIGN_EXT_EN (sign-extend instead of
// zero-extend the emitted values).
// Ports:
//   clk, rstn                  clock, async active-low reset
//   start                      latch config and begin a frame (IDLE only)
//   bitwidth_d [4:0]           packed value width (0 or >16 treated as 16)
//   num_of_output_values [31:0] values in the frame
//   rcv_valid/rcv_data/rcv_ready  packed word input handshake
//   trm_valid/trm_data/trm_last/trm_ready  unpacked value output handshake
//   done                       one-cycle pulse at frame end
// All outputs are flops; next values are computed from next-state so the
// handshake timing matches a purely state-derived interface (a word accepted
// in cycle t yields its first value in t+1).
// ---------------------------------------------------------------------------
module decompressor_ring
  import decompressor_ring_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [4:0]  bitwidth_d,
  input  logic [31:0] num_of_output_values,
  input  logic        rcv_valid,
  input  logic [15:0] rcv_data,
  output logic        rcv_ready,
  output logic        trm_valid,
  output logic [15:0] trm_data,
  output logic        trm_last,
  input  logic        trm_ready,
  output logic        done
);

  state_t                   state_q, state_d;
  logic [BUF_SIZE-1:0]      buf_q, buf_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [4:0]               bw_q, bw_d;
  logic [31:0]              n_q, n_d;
  logic [31:0]              out_cnt_q, out_cnt_d;
  logic [BITS_LEFT_W-1:0]   bits_left_q, bits_left_d;

  logic                     rcv_ready_q, rcv_ready_d;
  logic                     trm_valid_q, trm_valid_d;
  logic [15:0]              trm_data_q, trm_data_d;
  logic                     trm_last_q, trm_last_d;
  logic                     done_q, done_d;

  logic                     pop_s, push_s, done_pulse_s;
  logic [4:0]               start_bw_s;
  logic [FILL_W-1:0]        sh_s;
  logic [BUF_SIZE-1:0]      push_word_s;
  logic [15:0]              ext_value_s;

  assign pop_s       = trm_valid_q & trm_ready;
  assign push_s      = rcv_valid & rcv_ready_q;
  assign sh_s        = pop_s ? {1'b0, bw_q} : 6'd0;
  // New word lands directly above the bits that survive this cycle's pop.
  assign push_word_s = push_s ? ({16'd0, rcv_data} << (fill_q - sh_s)) : 32'd0;
  assign start_bw_s  = clamp_bw(bitwidth_d);

  // Frame control and bit-buffer next state.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    fill_d       = fill_q;
    bw_d         = bw_q;
    n_d          = n_q;
    out_cnt_d    = out_cnt_q;
    bits_left_d  = bits_left_q;
    done_pulse_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bw_d        = start_bw_s;
          n_d         = num_of_output_values;
          bits_left_d = 37'(num_of_output_values) * 37'(start_bw_s);
          fill_d      = 6'd0;
          buf_d       = 32'd0;
          out_cnt_d   = 32'd0;
          if (num_of_output_values == 32'd0) begin
            state_d      = S_IDLE;
            done_pulse_s = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        buf_d  = (buf_q >> sh_s) | push_word_s;
        fill_d = fill_q - sh_s + (push_s ? 6'd16 : 6'd0);
        if (push_s) begin
          bits_left_d = (bits_left_q > 37'd16) ? (bits_left_q - 37'd16) : 37'd0;
        end else begin
          bits_left_d = bits_left_q;
        end
        if (pop_s) begin
          out_cnt_d = out_cnt_q + 32'd1;
        end else begin
          out_cnt_d = out_cnt_q;
        end
        if (pop_s && trm_last_q) begin
          // Padding bits left after the final value are dropped.
          state_d = S_DONE;
          fill_d  = 6'd0;
          buf_d   = 32'd0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  decompressor_ring_extract u_extract (
    .bits_i  (buf_d[15:0]),
    .bw_i    (bw_d),
    .value_o (ext_value_s)
  );

  // Next values of the registered outputs, derived from next state.
  always_comb begin
    trm_valid_d = (state_d == S_RUN) && (fill_d >= {1'b0, bw_d});
    trm_last_d  = trm_valid_d && (out_cnt_d == (n_d - 32'd1));
    rcv_ready_d = (state_d == S_RUN) && (fill_d <= 6'd16) && (bits_left_d != 37'd0);
    done_d      = (state_d == S_DONE) || done_pulse_s;
    if (trm_valid_d) begin
      trm_data_d = ext_value_s;
    end else begin
      trm_data_d = 16'd0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      buf_q       <= 32'd0;
      fill_q      <= 6'd0;
      bw_q        <= 5'd0;
      n_q         <= 32'd0;
      out_cnt_q   <= 32'd0;
      bits_left_q <= 37'd0;
      rcv_ready_q <= 1'b0;
      trm_valid_q <= 1'b0;
      trm_data_q  <= 16'd0;
      trm_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      bw_q        <= bw_d;
      n_q         <= n_d;
      out_cnt_q   <= out_cnt_d;
      bits_left_q <= bits_left_d;
      rcv_ready_q <= rcv_ready_d;
      trm_valid_q <= trm_valid_d;
      trm_data_q  <= trm_data_d;
      trm_last_q  <= trm_last_d;
      done_q      <= done_d;
    end
  end

  assign rcv_ready = rcv_ready_q;
  assign trm_valid = trm_valid_q;
  assign trm_data  = trm_data_q;
  assign trm_last  = trm_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decompressor_ring.sv
// ---------------------------------------------------------------------------
// tb_decompressor_ring
// Table-driven bench for decompressor_ring: each record holds a frame
// configuration, the packed words and the raw value codes; expected outputs
// are the codes widened by the bench's own extension rule.
// ---------------------------------------------------------------------------
module tb_decompressor_ring;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  bitwidth_d = 5'd0;
  logic [31:0] num_of_output_values = 32'd0;
  logic        rcv_valid = 1'b0;
  logic [15:0] rcv_data = 16'd0;
  logic        rcv_ready;
  logic        trm_valid;
  logic [15:0] trm_data;
  logic        trm_last;
  logic        trm_ready = 1'b0;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decompressor_ring dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .bitwidth_d           (bitwidth_d),
    .num_of_output_values (num_of_output_values),
    .rcv_valid            (rcv_valid),
    .rcv_data             (rcv_data),
    .rcv_ready            (rcv_ready),
    .trm_valid            (trm_valid),
    .trm_data             (trm_data),
    .trm_last             (trm_last),
    .trm_ready            (trm_ready),
    .done                 (done)
  );

  typedef struct {
    logic [4:0]  bw;
    int          ebw;
    int          n;
    int          nwords;
    logic [15:0] words [4];
    logic [15:0] raw [16];
    bit          stall;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ext_ref(input logic [15:0] raw, input int w);
    logic [15:0] r;
    r = raw;
`ifdef DECOMP_SIGN_EXT_EN
    if (raw[w-1]) begin
      for (int b = w; b < 16; b++) r[b] = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int k = 0, wi = 0, cyc = 0;
    int first_acc = -1, first_val = -1, last_pop = -1, done_cyc = -1;
    bit prev_stall = 1'b0, fin = 1'b0, rdy;
    logic [15:0] prev_data = 16'd0;
    @(negedge clk);
    start = 1'b1; bitwidth_d = v.bw; num_of_output_values = 32'(v.n);
    trm_ready = 1'b0; rcv_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    // Config changes after start must be ignored.
    start = 1'b0; bitwidth_d = 5'd9; num_of_output_values = 32'd77;
    while (!fin && cyc < 300) begin
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check({tag, "_done_width"}, 64'(done), 64'd0);
        check({tag, "_rcv_ready_after"}, 64'(rcv_ready), 64'd0);
        check({tag, "_trm_valid_after"}, 64'(trm_valid), 64'd0);
        fin = 1'b1;
      end else begin
        if (prev_stall) check({tag, "_stall_hold"}, {47'd0, trm_valid, trm_data}, {47'd0, 1'b1, prev_data});
        rdy = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        trm_ready = rdy;
        rcv_valid = (wi < v.nwords);
        rcv_data  = (wi < v.nwords) ? v.words[wi] : 16'd0;
        prev_stall = trm_valid && !rdy;
        prev_data  = trm_data;
        if (trm_valid && first_val < 0) first_val = cyc;
        if (trm_valid && rdy) begin
          if (k < v.n) begin
            check($sformatf("%s_val%0d", tag, k), 64'(trm_data), 64'(ext_ref(v.raw[k], v.ebw)));
            check($sformatf("%s_last%0d", tag, k), 64'(trm_last), 64'(k == v.n - 1));
          end else begin
            check({tag, "_extra_value"}, 64'(k), 64'(v.n));
          end
          last_pop = cyc;
          k++;
        end
        if (rcv_valid && rcv_ready) begin
          if (first_acc < 0) first_acc = cyc;
          wi++;
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
    end
    trm_ready = 1'b0; rcv_valid = 1'b0;
    if (!fin) check({tag, "_timeout"}, 64'(cyc), 64'd0);
    check({tag, "_value_count"}, 64'(k), 64'(v.n));
    check({tag, "_words_used"}, 64'(wi), 64'(v.nwords));
    check({tag, "_latency"}, 64'(first_val), 64'(first_acc + 1));
    check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_pop + 1));
    if (!v.stall) check({tag, "_throughput"}, 64'(done_cyc - first_val), 64'(v.n));
  endtask

  initial begin
    int pops;
    // bw=16 N=2
    vecs[0].bw = 5'd16; vecs[0].ebw = 16; vecs[0].n = 2; vecs[0].nwords = 2; vecs[0].stall = 1'b0;
    vecs[0].words[0] = 16'h1234; vecs[0].words[1] = 16'hBEEF;
    vecs[0].raw[0] = 16'h1234; vecs[0].raw[1] = 16'hBEEF;
    // bw=4 N=8: nibbles 1..8
    vecs[1].bw = 5'd4; vecs[1].ebw = 4; vecs[1].n = 8; vecs[1].nwords = 2; vecs[1].stall = 1'b0;
    vecs[1].words[0] = 16'h4321; vecs[1].words[1] = 16'h8765;
    for (int i = 0; i < 8; i++) vecs[1].raw[i] = 16'(i + 1);
    // bw=5 N=3 from a single word
    vecs[2].bw = 5'd5; vecs[2].ebw = 5; vecs[2].n = 3; vecs[2].nwords = 1; vecs[2].stall = 1'b0;
    vecs[2].words[0] = 16'h17E3;
    vecs[2].raw[0] = 16'h0003; vecs[2].raw[1] = 16'h001F; vecs[2].raw[2] = 16'h0005;
    // bw=3 N=16: codes 0..7 twice, stream 0xFAC688FAC688, random stalls
    vecs[3].bw = 5'd3; vecs[3].ebw = 3; vecs[3].n = 16; vecs[3].nwords = 3; vecs[3].stall = 1'b1;
    vecs[3].words[0] = 16'hC688; vecs[3].words[1] = 16'h88FA; vecs[3].words[2] = 16'hFAC6;
    for (int i = 0; i < 16; i++) vecs[3].raw[i] = 16'(i % 8);
    // bw=0 behaves as 16
    vecs[4].bw = 5'd0; vecs[4].ebw = 16; vecs[4].n = 1; vecs[4].nwords = 1; vecs[4].stall = 1'b0;
    vecs[4].words[0] = 16'hA5A5; vecs[4].raw[0] = 16'hA5A5;
    // bw=1 N=5: bits 0,1,1,0,1
    vecs[5].bw = 5'd1; vecs[5].ebw = 1; vecs[5].n = 5; vecs[5].nwords = 1; vecs[5].stall = 1'b1;
    vecs[5].words[0] = 16'h0016;
    vecs[5].raw[0] = 16'd0; vecs[5].raw[1] = 16'd1; vecs[5].raw[2] = 16'd1;
    vecs[5].raw[3] = 16'd0; vecs[5].raw[4] = 16'd1;

    repeat (3) @(negedge clk);
    check("reset_outputs", {44'd0, rcv_ready, trm_valid, trm_data, trm_last, done}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) run_frame(vecs[r], $sformatf("vec%0d", r));

    // N=0: no handshakes, done one cycle after start
    @(negedge clk);
    start = 1'b1; bitwidth_d = 5'd4; num_of_output_values = 32'd0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("n0_done", {62'd0, done, 1'b0}, {62'd0, 1'b1, 1'b0});
    check("n0_idle_hs", {62'd0, rcv_ready, trm_valid}, 64'd0);
    @(negedge clk);
    check("n0_done_clear", {61'd0, done, rcv_ready, trm_valid}, 64'd0);

    // Reset mid-frame after three values, with an ignored start during RUN
    start = 1'b1; bitwidth_d = 5'd7; num_of_output_values = 32'd6;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    pops = 0;
    for (int c = 0; c < 40 && pops < 3; c++) begin
      rcv_valid = 1'b1; rcv_data = 16'h5555; trm_ready = 1'b1;
      if (trm_valid) pops++;
      @(posedge clk); @(negedge clk);
    end
    check("rst_pre_pops", 64'(pops), 64'd3);
    trm_ready = 1'b0; rcv_valid = 1'b0;
    start = 1'b1; num_of_output_values = 32'd0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("start_ignored_in_run", {62'd0, done, trm_valid}, {62'd0, 1'b0, 1'b1});
    rstn = 1'b0;
    #1;
    check("rst_async_outputs", {44'd0, rcv_ready, trm_valid, trm_data, trm_last, done}, 64'd0);
    @(negedge clk);
    check("rst_held_outputs", {44'd0, rcv_ready, trm_valid, trm_data, trm_last, done}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {44'd0, rcv_ready, trm_valid, trm_data, trm_last, done}, 64'd0);
    run_frame(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
